cache_line_axi_master: RTL and testbench

- AXI master for the L1 cache miss path.
- Converts a line-fill request into one 4-beat INCR read burst, and a write-through store into one single-beat write.
- Sits directly upstream of the interconnect that feeds the DRAM slave wrapper.
- Presents the DRAM slave with ARLEN=3 bursts and AWLEN=0 writes, one transaction outstanding at a time.

---
 rtl/cache_line_axi_master_pkg.sv | 31 +++
 rtl/cache_line_axi_master_if.sv | 72 +++++++
 rtl/cache_line_axi_master.sv | 202 ++++++++++++++++++++
 tb/tb_cache_line_axi_master.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_line_axi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_axi_master_pkg
// Purpose  : Shared AXI widths, response/burst constants and the FSM state
//            type for the L1 miss-path AXI master.
// Revision : 1.0 - initial release
// ============================================================================
package cache_line_axi_master_pkg;

    localparam int c_id_w   = 4;
    localparam int c_addr_w = 32;
    localparam int c_data_w = 32;
    localparam int c_len_w  = 4;
    localparam int c_size_w = 3;
    localparam int c_strb_w = 4;

    localparam logic [1:0]          c_burst_incr = 2'b01;
    localparam logic [1:0]          c_resp_okay  = 2'b00;
    localparam logic [c_size_w-1:0] c_size_word  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_line_axi_master_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_axi_master_if
// Purpose  : AXI read/write channel bundle between the miss-path master and
//            the interconnect.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_line_axi_master_if;
    import cache_line_axi_master_pkg::*;

    logic [c_id_w-1:0]   arid;
    logic [c_addr_w-1:0] araddr;
    logic [c_len_w-1:0]  arlen;
    logic [c_size_w-1:0] arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [c_id_w-1:0]   rid;
    logic [c_data_w-1:0] rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [c_id_w-1:0]   awid;
    logic [c_addr_w-1:0] awaddr;
    logic [c_len_w-1:0]  awlen;
    logic [c_size_w-1:0] awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [c_data_w-1:0] wdata;
    logic [c_strb_w-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [c_id_w-1:0]   bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface
`default_nettype wire

// File: rtl/cache_line_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : cache_line_axi_master
// Purpose  : L1 miss-path AXI master: line fill as one 4-beat INCR read,
//            write-through store as one single-beat write.
// Revision : 1.0 - initial release
// ============================================================================
module cache_line_axi_master
    import cache_line_axi_master_pkg::*;
#(
    parameter logic [c_id_w-1:0] MASTER_ID = 4'd1
) (
    input  wire logic                clk,
    input  wire logic                rst,

    input  wire logic                req_valid,
    output logic                     req_ready,
    input  wire logic                req_write,
    input  wire logic [c_addr_w-1:0] req_addr,
    input  wire logic [c_data_w-1:0] req_wdata,
    input  wire logic [c_strb_w-1:0] req_wstrb,
    output logic                     line_valid,
    output logic [127:0]             line_data,
    output logic                     wr_done,
    output logic                     resp_err,

    cache_line_axi_master_if.master  axi
);

    localparam int LINE_WORDS = 4;

    state_t                r_state;
    logic                  r_req_ready;
    logic [c_addr_w-1:0]   r_araddr;
    logic [c_addr_w-1:0]   r_awaddr;
    logic [c_data_w-1:0]   r_wdata;
    logic [c_strb_w-1:0]   r_wstrb;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_wlast;
    logic                  r_bready;
    logic [1:0]            r_beat;
    logic                  r_err;
    logic [c_data_w-1:0]   r_line_buf [LINE_WORDS];
    logic [127:0]          r_line_data;
    logic                  r_line_valid;
    logic                  r_wr_done;
    logic                  r_resp_err;

    logic                  w_accept;
    logic                  w_beat_err;
    logic [127:0]          w_line_next;
    logic                  w_unused;

    assign w_accept   = req_valid && r_req_ready;
    assign w_beat_err = (axi.rresp != c_resp_okay) || (axi.rlast != (r_beat == 2'd3));

    // The final beat bypasses the buffer so the full line is published in one edge.
    always_comb begin
        w_line_next = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            w_line_next[i*32 +: 32] = (r_beat == 2'(i)) ? axi.rdata : r_line_buf[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_araddr     <= '0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
            r_bready     <= 1'b0;
            r_beat       <= 2'd0;
            r_err        <= 1'b0;
            r_line_data  <= '0;
            r_line_valid <= 1'b0;
            r_wr_done    <= 1'b0;
            r_resp_err   <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_line_buf[i] <= '0;
            end
        end else begin
            r_line_valid <= 1'b0;
            r_wr_done    <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_err       <= 1'b0;
                        r_araddr    <= {req_addr[31:4], 4'h0};
                        r_awaddr    <= {req_addr[31:2], 2'b00};
                        r_wdata     <= req_wdata;
                        r_wstrb     <= req_wstrb;
                        if (req_write) begin
                            r_awvalid <= 1'b1;
                            r_state   <= ST_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= 2'd0;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (axi.rvalid) begin
                        r_line_buf[r_beat] <= axi.rdata;
                        r_beat             <= r_beat + 2'd1;
                        if (w_beat_err) begin
                            r_err <= 1'b1;
                        end
                        // Beat count, not RLAST, terminates the burst.
                        if (r_beat == 2'd3) begin
                            r_rready     <= 1'b0;
                            r_line_data  <= w_line_next;
                            r_line_valid <= 1'b1;
                            r_resp_err   <= r_err | w_beat_err;
                            r_req_ready  <= 1'b1;
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                ST_AW: begin
                    if (axi.awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_wlast   <= 1'b1;
                        r_state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (axi.wready) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= ST_B;
                    end
                end
                ST_B: begin
                    if (axi.bvalid) begin
                        r_bready    <= 1'b0;
                        r_wr_done   <= 1'b1;
                        r_resp_err  <= r_err | (axi.bresp != c_resp_okay);
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign line_valid  = r_line_valid;
    assign line_data   = r_line_data;
    assign wr_done     = r_wr_done;
    assign resp_err    = r_resp_err;

    assign axi.arid    = MASTER_ID;
    assign axi.araddr  = r_araddr;
    assign axi.arlen   = 4'd3;
    assign axi.arsize  = c_size_word;
    assign axi.arburst = c_burst_incr;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

    assign axi.awid    = MASTER_ID;
    assign axi.awaddr  = r_awaddr;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = c_size_word;
    assign axi.awburst = c_burst_incr;
    assign axi.awvalid = r_awvalid;

    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wlast   = r_wlast;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;

    // Only one transaction is ever outstanding, so response IDs are ignored.
    assign w_unused = ^{axi.rid, axi.bid, req_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_cache_line_axi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_line_axi_master
// Purpose  : Randomized self-checking bench with a transaction-level model of
//            the cache miss path and an AXI slave driven from tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_axi_master;
    import cache_line_axi_master_pkg::*;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         line_valid;
    logic [127:0] line_data;
    logic         wr_done;
    logic         resp_err;

    cache_line_axi_master_if axi ();

    cache_line_axi_master #(.MASTER_ID(4'd1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .line_valid (line_valid),
        .line_data  (line_data),
        .wr_done    (wr_done),
        .resp_err   (resp_err),
        .axi        (axi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_r = 0, n_lv = 0, n_wd = 0;
    int e_ar = 0, e_aw = 0, e_w = 0, e_b = 0, e_r = 0, e_lv = 0, e_wd = 0;
    logic [127:0] last_line = '0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor: every AXI transfer and completion pulse is counted once.
    always @(posedge clk) begin
        if (!rst) begin
            if (axi.arvalid && axi.arready) n_ar++;
            if (axi.awvalid && axi.awready) n_aw++;
            if (axi.wvalid  && axi.wready)  n_w++;
            if (axi.bvalid  && axi.bready)  n_b++;
            if (axi.rvalid  && axi.rready)  n_r++;
            if (line_valid) n_lv++;
            if (wr_done)    n_wd++;
        end
    end

    task automatic send_req(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit hold);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        for (int t = 0; t < 20 && !req_ready; t++) @(negedge clk);
        if (!req_ready) check_eq("req_ready_timeout", 0, 1);
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] addr, input logic [127:0] words, input int ar_dly,
                           input int max_gap, input int err_beat, input int rlast_bad,
                           input int rst_after, input bit hold);
        logic [31:0] exp_addr;
        bit          exp_err;
        bit          aborted;
        exp_addr = addr & 32'hFFFF_FFF0;
        exp_err  = (err_beat >= 0) || (rlast_bad >= 0);
        aborted  = 1'b0;
        send_req(1'b0, addr, 32'h0, 4'h0, hold);
        check_eq("ar_valid_latency", axi.arvalid, 1);
        for (int t = 0; t < 10 && !axi.arvalid; t++) @(negedge clk);
        check_eq("ar_addr",  axi.araddr, exp_addr);
        check_eq("ar_len",   axi.arlen, 3);
        check_eq("ar_size",  axi.arsize, 2);
        check_eq("ar_burst", axi.arburst, 1);
        check_eq("ar_id",    axi.arid, 1);
        repeat (ar_dly) begin
            @(negedge clk);
            check_eq("ar_hold", {axi.arvalid, axi.araddr, axi.arlen}, {1'b1, exp_addr, 4'd3});
        end
        axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        e_ar++;
        check_eq("ar_drop", axi.arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            axi.rvalid = 1'b1;
            axi.rdata  = words[i*32 +: 32];
            axi.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            axi.rlast  = (i == 3) ^ (i == rlast_bad);
            check_eq("r_ready", axi.rready, 1);
            @(negedge clk);
            axi.rvalid = 1'b0;
            axi.rlast  = 1'b0;
            axi.rresp  = 2'b00;
            e_r++;
            if (i < 3 && i != rst_after) check_eq("line_valid_early", line_valid, 0);
            if (i == rst_after) begin
                rst = 1'b1;
                #1;
                check_eq("rst_outputs",
                         {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                          line_valid, wr_done, resp_err},
                         8'h00);
                check_eq("rst_line_data", line_data, 0);
                @(negedge clk);
                rst = 1'b0;
                last_line = '0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("rst_no_pulse", line_valid, 0);
                end
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            e_lv++;
            last_line = words;
            check_eq("line_valid", line_valid, 1);
            check_eq("line_data",  line_data, words);
            check_eq("fill_resp_err", resp_err, exp_err);
            check_eq("fill_req_ready", req_ready, 1);
            if (!hold) begin
                @(negedge clk);
                check_eq("line_valid_pulse", {line_valid, resp_err}, 0);
                check_eq("line_data_keep", line_data, words);
            end
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] bresp, input bit hold);
        logic [31:0] exp_addr;
        exp_addr = addr & 32'hFFFF_FFFC;
        send_req(1'b1, addr, data, strb, hold);
        check_eq("aw_valid_latency", axi.awvalid, 1);
        for (int t = 0; t < 10 && !axi.awvalid; t++) @(negedge clk);
        check_eq("aw_addr",  axi.awaddr, exp_addr);
        check_eq("aw_len",   axi.awlen, 0);
        check_eq("aw_size",  axi.awsize, 2);
        check_eq("aw_burst", axi.awburst, 1);
        check_eq("aw_id",    axi.awid, 1);
        repeat (aw_dly) begin
            @(negedge clk);
            check_eq("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, exp_addr});
        end
        axi.awready = 1'b1;
        @(negedge clk);
        axi.awready = 1'b0;
        e_aw++;
        for (int t = 0; t < 10 && !axi.wvalid; t++) @(negedge clk);
        check_eq("w_beat", {axi.awvalid, axi.wvalid, axi.wlast, axi.wdata, axi.wstrb},
                 {1'b0, 1'b1, 1'b1, data, strb});
        repeat (w_dly) begin
            @(negedge clk);
            check_eq("w_hold", {axi.wvalid, axi.wdata, axi.wstrb}, {1'b1, data, strb});
        end
        axi.wready = 1'b1;
        @(negedge clk);
        axi.wready = 1'b0;
        e_w++;
        check_eq("b_ready", {axi.wvalid, axi.bready}, 2'b01);
        repeat (b_dly) begin
            @(negedge clk);
            check_eq("b_wait_no_done", wr_done, 0);
        end
        axi.bvalid = 1'b1;
        axi.bresp  = bresp;
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        e_b++;
        e_wd++;
        check_eq("wr_done", wr_done, 1);
        check_eq("store_resp_err", resp_err, bresp != 2'b00);
        check_eq("store_line_keep", line_data, last_line);
        check_eq("store_req_ready", req_ready, 1);
        if (!hold) begin
            @(negedge clk);
            check_eq("wr_done_pulse", {wr_done, resp_err}, 0);
        end
    endtask

    initial begin
        logic [127:0] w;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        axi.arready = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rid     = 4'd1;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("reset_valids",
                 {axi.arvalid, axi.awvalid, axi.wvalid, axi.wlast, axi.rready, axi.bready,
                  line_valid, wr_done, resp_err}, 9'h000);
        check_eq("reset_line_data", line_data, 0);
        check_eq("reset_consts", {axi.arid, axi.awid, axi.arlen, axi.awlen, axi.arsize,
                                  axi.awsize, axi.arburst, axi.awburst},
                 {4'd1, 4'd1, 4'd3, 4'd0, 3'd2, 3'd2, 2'd1, 2'd1});

        w = {32'h44, 32'h33, 32'h22, 32'h11};
        do_fill(32'h0000_1238, w, 3, 0, -1, -1, -1, 1'b0);
        do_fill(32'h0000_1238, w, 0, 5, -1, -1, -1, 1'b0);
        do_store(32'h0000_2006, 32'hDEAD_BEEF, 4'b1100, 2, 2, 2, 2'b00, 1'b0);

        do_fill(32'h0000_5000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1, 1, 2, -1, -1, 1'b0);
        do_store(32'h0000_5008, 32'h1234_5678, 4'b1111, 0, 0, 0, 2'b00, 1'b0);
        do_fill(32'h0000_6010, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 0, 0, -1, 1, -1, 1'b0);
        do_fill(32'h0000_6010, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 0, 0, -1, -1, -1, 1'b0);
        do_store(32'h0000_7000, 32'h0BAD_F00D, 4'b0011, 1, 0, 1, 2'b10, 1'b0);

        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                do_fill(32'h0000_3000 + 32'(k * 16),
                        {$urandom, $urandom, $urandom, $urandom}, 0, 0, -1, -1, -1, 1'b1);
            else
                do_store(32'h0000_4000 + 32'(k * 4), $urandom, 4'(k), 0, 0, 0, 2'b00, 1'b1);
        end
        req_valid = 1'b0;
        @(negedge clk);

        do_fill(32'h0000_8000, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 0, 0, -1, -1, 1, 1'b0);
        do_fill(32'h0000_8040, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 1, 2, -1, -1, -1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_store($urandom, $urandom, 4'($urandom), $urandom_range(3, 0),
                         $urandom_range(3, 0), $urandom_range(3, 0),
                         ($urandom_range(3, 0) == 0) ? 2'b11 : 2'b00, 1'b0);
            end else begin
                do_fill($urandom, {$urandom, $urandom, $urandom, $urandom},
                        $urandom_range(3, 0), 3,
                        ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                        ($urandom_range(3, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
                        -1, 1'b0);
            end
        end

        repeat (3) @(negedge clk);
        check_eq("cnt_ar", n_ar, e_ar);
        check_eq("cnt_r",  n_r,  e_r);
        check_eq("cnt_aw", n_aw, e_aw);
        check_eq("cnt_w",  n_w,  e_w);
        check_eq("cnt_b",  n_b,  e_b);
        check_eq("cnt_line_valid", n_lv, e_lv);
        check_eq("cnt_wr_done",    n_wd, e_wd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
